// File: rtl/pll_phase_ctrl_pkg.sv
// Shared definitions for the PLL dynamic phase-shift controller.
//   state_e      : controller FSM states
//   DEF_*        : default pulse/gap/settle timing in clk cycles
//   MATH_W       : width used for all modulo position arithmetic
//   step_pos()   : +/-1 position step with wrap at STEPS
package pll_phase_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE_HI,
    ST_PULSE_LO,
    ST_WAIT_LOCK,
    ST_SETTLE
  } state_e;

  localparam int unsigned DEF_PULSE_HIGH = 4;
  localparam int unsigned DEF_PULSE_GAP  = 4;
  localparam int unsigned DEF_SETTLE     = 16;

  // One bit wider than a position so sums such as target+STEPS never overflow
  // for STEPS up to 127.
  localparam int unsigned MATH_W = 8;

  // Advance a position by one step: dir=0 -> +1, dir=1 -> -1, modulo steps.
  function automatic logic [6:0] step_pos(input logic [6:0] pos,
                                          input logic       dir,
                                          input logic [7:0] steps);
    logic [7:0] p;
    logic [7:0] r;
    p = {1'b0, pos};
    if (!dir) r = ((p + 8'd1) == steps) ? '0 : (p + 8'd1);
    else      r = (p == '0) ? (steps - 8'd1) : (p - 8'd1);
    return 7'(r);
  endfunction

endpackage

// File: rtl/pll_phase_dist.sv
// Shortest-direction calculator for the phase controller (combinational).
//   cur_pos_i : current tracked position (< STEPS)
//   target_i  : requested position (< STEPS; caller screens out-of-range)
//   dir_o     : 0 = step forward (+1), 1 = step backward (-1)
//   count_o   : number of single steps needed, min(fwd, bwd)
module pll_phase_dist
  import pll_phase_ctrl_pkg::*;
#(
  parameter int unsigned STEPS = 80
) (
  input  logic [6:0]        cur_pos_i,
  input  logic [6:0]        target_i,
  output logic              dir_o,
  output logic [MATH_W-1:0] count_o
);

  localparam logic [MATH_W-1:0] STEPS_W = MATH_W'(STEPS);

  logic [MATH_W-1:0] cur_w;
  logic [MATH_W-1:0] tgt_w;
  logic [MATH_W-1:0] fwd;
  logic [MATH_W-1:0] bwd;

  always_comb begin
    cur_w = {1'b0, cur_pos_i};
    tgt_w = {1'b0, target_i};
    // (target - cur) mod STEPS without a signed intermediate.
    if (tgt_w >= cur_w) fwd = tgt_w - cur_w;
    else                fwd = tgt_w + STEPS_W - cur_w;
    bwd = STEPS_W - fwd;
    // Ties go forward.
    if (fwd <= bwd) begin
      dir_o   = 1'b0;
      count_o = fwd;
    end else begin
      dir_o   = 1'b1;
      count_o = bwd;
    end
  end

endmodule

// File: rtl/pll_phase_ctrl.sv
// PLL dynamic phase-shift controller. Accepts a target phase position and
// walks the PLL there one PSPULSE at a time along the shorter direction,
// tracking the position locally (reset must accompany the PLL reset).
//   clk, reset            : single clock, synchronous active-high reset
//   pll_lock              : PLL LOCK; pulses only issue while locked
//   req_valid/req_target  : request handshake, accepted when req_ready=1
//   req_ready             : high only in IDLE with pll_lock=1
//   ps_sel/ps_dir/ps_pulse: PLL PSSEL/PSDIR/PSPULSE
//   cur_pos               : tracked phase position
//   busy/done/err         : FSM not idle / completion pulse / reject pulse
module pll_phase_ctrl
  import pll_phase_ctrl_pkg::*;
#(
  parameter int unsigned STEPS      = 80,
  parameter int unsigned INIT_POS   = 51,
  parameter int unsigned PS_CHANNEL = 2,
  parameter int unsigned PULSE_HIGH = DEF_PULSE_HIGH,
  parameter int unsigned PULSE_GAP  = DEF_PULSE_GAP,
  parameter int unsigned SETTLE     = DEF_SETTLE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       req_valid,
  input  logic [6:0] req_target,
  output logic       req_ready,
  output logic [2:0] ps_sel,
  output logic       ps_dir,
  output logic       ps_pulse,
  output logic [6:0] cur_pos,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [MATH_W-1:0] STEPS_W     = MATH_W'(STEPS);
  localparam logic [7:0]        HI_LAST     = 8'(PULSE_HIGH - 1);
  localparam logic [7:0]        LO_LAST     = 8'(PULSE_GAP - 1);
  localparam logic [7:0]        SETTLE_LAST = 8'(SETTLE - 1);

  state_e            state_q;
  logic [6:0]        pos_q;
  logic              dir_q;
  logic              pulse_q;
  logic              done_q;
  logic              err_q;
  logic [7:0]        tmr_q;
  logic [MATH_W-1:0] rem_q;

  logic              dist_dir;
  logic [MATH_W-1:0] dist_cnt;
  logic [6:0]        pos_d;
  logic [MATH_W-1:0] rem_d;
  logic              accept;

  pll_phase_dist #(
    .STEPS (STEPS)
  ) u_dist (
    .cur_pos_i (pos_q),
    .target_i  (req_target),
    .dir_o     (dist_dir),
    .count_o   (dist_cnt)
  );

  assign pos_d     = step_pos(pos_q, dir_q, STEPS_W);
  assign rem_d     = rem_q - 1'b1;
  assign req_ready = (state_q == ST_IDLE) && pll_lock;
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pos_q   <= 7'(INIT_POS);
      dir_q   <= 1'b0;
      pulse_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      tmr_q   <= '0;
      rem_q   <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if ({1'b0, req_target} >= STEPS_W) begin
              err_q <= 1'b1;
            end else if (req_target == pos_q) begin
              done_q <= 1'b1;
            end else begin
              dir_q   <= dist_dir;
              rem_q   <= dist_cnt;
              state_q <= ST_SETUP;
            end
          end
        end
        ST_SETUP: begin
          state_q <= ST_PULSE_HI;
          pulse_q <= 1'b1;
          tmr_q   <= '0;
        end
        ST_PULSE_HI: begin
          if (tmr_q == HI_LAST) begin
            state_q <= ST_PULSE_LO;
            pulse_q <= 1'b0;
            tmr_q   <= '0;
          end else begin
            tmr_q <= tmr_q + 8'd1;
          end
        end
        ST_PULSE_LO: begin
          if (tmr_q == LO_LAST) begin
            pos_q <= pos_d;
            rem_q <= rem_d;
            tmr_q <= '0;
            // Lock is only consulted here, so a pulse in flight always
            // completes its high and low phases.
            if (!pll_lock) begin
              state_q <= ST_WAIT_LOCK;
            end else if (rem_d != '0) begin
              state_q <= ST_PULSE_HI;
              pulse_q <= 1'b1;
            end else begin
              state_q <= ST_SETTLE;
            end
          end else begin
            tmr_q <= tmr_q + 8'd1;
          end
        end
        ST_WAIT_LOCK: begin
          if (pll_lock) begin
            tmr_q <= '0;
            if (rem_q != '0) begin
              state_q <= ST_PULSE_HI;
              pulse_q <= 1'b1;
            end else begin
              state_q <= ST_SETTLE;
            end
          end
        end
        ST_SETTLE: begin
          if (tmr_q == SETTLE_LAST) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
            tmr_q   <= '0;
          end else begin
            tmr_q <= tmr_q + 8'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          pulse_q <= 1'b0;
        end
      endcase
    end
  end

  assign ps_sel   = 3'(PS_CHANNEL);
  assign ps_dir   = dir_q;
  assign ps_pulse = pulse_q;
  assign cur_pos  = pos_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign err      = err_q;

endmodule
